// File: rtl/eth_player_pkg.sv
// Shared types and width helpers for the Ethernet RX frame player.
package eth_player_pkg;

  localparam int unsigned CfgLenW = 16;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StPlay,
    StGap,
    StStatus,
    StWaitRise,
    StWaitFall,
    StIfg,
    StNext
  } state_e;

  typedef struct packed {
    logic [CfgLenW-1:0] len;
    logic               bad;
    logic               need_answer;
  } slot_cfg_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned nf, input int unsigned ml);
    return clog2_min1(nf * ml);
  endfunction

  function automatic int unsigned slot_w(input int unsigned nf);
    return clog2_min1(nf);
  endfunction

  function automatic int unsigned len_w(input int unsigned ml);
    return $clog2(ml + 1);
  endfunction

endpackage

// File: rtl/eth_player_ram.sv
// Frame byte store: one write port, one synchronous read port (1-cycle latency).
module eth_player_ram #(
  parameter int unsigned DEPTH  = 6144,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_player.sv
// Replays stored frames onto a MAC-RX byte interface with good/bad status strobes.
// Optional answer-wait timeout enabled by defining ANSWER_TIMEOUT_EN.
module eth_rx_frame_player
  import eth_player_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned MAX_LEN     = 1536,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned ANS_TIMEOUT = 65535
) (
  input  logic                                 eth_rx_clk,
  input  logic                                 rst,
  input  logic                                 cfg_we,
  input  logic [addr_w(NUM_FRAMES, MAX_LEN)-1:0] cfg_addr,
  input  logic [7:0]                           cfg_data,
  input  logic                                 cfg_len_we,
  input  logic [slot_w(NUM_FRAMES)-1:0]        cfg_slot,
  input  logic [len_w(MAX_LEN)-1:0]            cfg_len,
  input  logic                                 cfg_bad,
  input  logic                                 cfg_need_answer,
  input  logic                                 start,
  input  logic                                 loop,
  input  logic                                 eth_tx_data_en,
  output logic [7:0]                           eth_rx_data,
  output logic                                 eth_rx_data_valid,
  output logic                                 eth_rx_frame_good,
  output logic                                 eth_rx_frame_bad,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          frame_cnt,
  output logic                                 ans_err
);

  localparam int unsigned AW = addr_w(NUM_FRAMES, MAX_LEN);
  localparam int unsigned SW = slot_w(NUM_FRAMES);
  localparam int unsigned LW = len_w(MAX_LEN);

  state_e          state;
  logic [SW-1:0]   slot;
  logic [SW-1:0]   slot_nxt;
  logic [LW-1:0]   cnt;
  logic [15:0]     gcnt;
  slot_cfg_t       cur;
  slot_cfg_t       tbl [NUM_FRAMES];
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   base_cur;
  logic [AW-1:0]   base_nxt;
  logic [7:0]      ram_q;
  logic            last_slot;

`ifdef ANSWER_TIMEOUT_EN
  logic [31:0]     tcnt;
`endif

  eth_player_ram #(
    .DEPTH (NUM_FRAMES * MAX_LEN),
    .ADDR_W(AW)
  ) u_ram (
    .clk  (eth_rx_clk),
    .we   (cfg_we & ~busy),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

  always_ff @(posedge eth_rx_clk) begin
    if (cfg_len_we && !busy) begin
      tbl[cfg_slot].len         <= (cfg_len > LW'(MAX_LEN)) ? CfgLenW'(MAX_LEN)
                                                            : CfgLenW'(cfg_len);
      tbl[cfg_slot].bad         <= cfg_bad;
      tbl[cfg_slot].need_answer <= cfg_need_answer;
    end
  end

  assign last_slot = (slot == SW'(NUM_FRAMES - 1));
  assign slot_nxt  = last_slot ? '0 : slot + 1'b1;
  assign base_cur  = AW'(slot) * AW'(MAX_LEN);
  assign base_nxt  = AW'(slot_nxt) * AW'(MAX_LEN);

  // Read address runs one byte ahead of the output register to hide RAM latency.
  always_comb begin
    rd_addr = base_cur;
    unique case (state)
      StIdle:  rd_addr = '0;
      StFetch: rd_addr = base_cur + AW'(1);
      StPlay:  rd_addr = base_cur + AW'(cnt) + AW'(2);
      StNext:  rd_addr = base_nxt;
      default: rd_addr = base_cur;
    endcase
  end

  always_ff @(posedge eth_rx_clk) begin
    if (rst) begin
      state             <= StIdle;
      slot              <= '0;
      cnt               <= '0;
      gcnt              <= '0;
      cur               <= '0;
      eth_rx_data       <= '0;
      eth_rx_data_valid <= 1'b0;
      eth_rx_frame_good <= 1'b0;
      eth_rx_frame_bad  <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      frame_cnt         <= '0;
`ifdef ANSWER_TIMEOUT_EN
      tcnt              <= '0;
      ans_err           <= 1'b0;
`endif
    end else begin
      eth_rx_data       <= '0;
      eth_rx_data_valid <= 1'b0;
      eth_rx_frame_good <= 1'b0;
      eth_rx_frame_bad  <= 1'b0;
      done              <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy      <= 1'b1;
            slot      <= '0;
            frame_cnt <= '0;
            state     <= StFetch;
          end
        end
        StFetch: begin
          cur <= tbl[slot];
          if (tbl[slot].len == '0) begin
            state <= StNext;
          end else begin
            eth_rx_data_valid <= 1'b1;
            eth_rx_data       <= ram_q;
            cnt               <= '0;
            state             <= StPlay;
          end
        end
        StPlay: begin
          if (CfgLenW'(cnt) == cur.len - CfgLenW'(1)) begin
            gcnt  <= '0;
            state <= StGap;
          end else begin
            eth_rx_data_valid <= 1'b1;
            eth_rx_data       <= ram_q;
            cnt               <= cnt + 1'b1;
          end
        end
        StGap: begin
          if (gcnt == 16'(GAP_CYCLES - 1)) begin
            eth_rx_frame_good <= ~cur.bad;
            eth_rx_frame_bad  <= cur.bad;
            frame_cnt         <= frame_cnt + 32'd1;
            state             <= StStatus;
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        StStatus: begin
          gcnt  <= '0;
`ifdef ANSWER_TIMEOUT_EN
          tcnt  <= '0;
`endif
          state <= cur.need_answer ? StWaitRise : StIfg;
        end
        StWaitRise: begin
`ifdef ANSWER_TIMEOUT_EN
          tcnt <= tcnt + 32'd1;
          if (tcnt == 32'(ANS_TIMEOUT - 1)) begin
            ans_err <= 1'b1;
            state   <= StIfg;
          end
`endif
          // A reply already in flight on entry counts as the rise.
          if (eth_tx_data_en) begin
`ifdef ANSWER_TIMEOUT_EN
            tcnt <= '0;
`endif
            state <= StWaitFall;
          end
        end
        StWaitFall: begin
`ifdef ANSWER_TIMEOUT_EN
          tcnt <= tcnt + 32'd1;
          if (tcnt == 32'(ANS_TIMEOUT - 1)) begin
            ans_err <= 1'b1;
            state   <= StIfg;
          end
`endif
          if (!eth_tx_data_en) state <= StIfg;
        end
        StIfg: begin
          if (gcnt == 16'(IFG_CYCLES - 1)) begin
            state <= StNext;
          end else begin
            gcnt <= gcnt + 16'd1;
          end
        end
        StNext: begin
          if (!last_slot) begin
            slot  <= slot + 1'b1;
            state <= StFetch;
          end else if (loop) begin
            slot  <= '0;
            state <= StFetch;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifndef ANSWER_TIMEOUT_EN
  assign ans_err = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_player.sv
// Directed bench for eth_rx_frame_player: replay, skip, loop, clamp, reset and answer-wait.
module tb_eth_rx_frame_player;

  localparam int NF  = 4;
  localparam int ML  = 1536;
  localparam int GAP = 4;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [12:0] cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_len_we;
  logic [1:0]  cfg_slot;
  logic [10:0] cfg_len;
  logic        cfg_bad;
  logic        cfg_need_answer;
  logic        start;
  logic        lp;
  logic        tx_en;
  logic [7:0]  data;
  logic        valid;
  logic        good;
  logic        bad;
  logic        busy;
  logic        done;
  logic [31:0] frame_cnt;
  logic        ans_err;

  int errors = 0;
  int checks = 0;
  int vcnt = 0;
  int gcnt = 0;
  int bcnt = 0;

  eth_rx_frame_player #(
    .NUM_FRAMES (NF),
    .MAX_LEN    (ML),
    .GAP_CYCLES (GAP),
    .IFG_CYCLES (12),
    .ANS_TIMEOUT(100)
  ) dut (
    .eth_rx_clk       (clk),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .cfg_len_we       (cfg_len_we),
    .cfg_slot         (cfg_slot),
    .cfg_len          (cfg_len),
    .cfg_bad          (cfg_bad),
    .cfg_need_answer  (cfg_need_answer),
    .start            (start),
    .loop             (lp),
    .eth_tx_data_en   (tx_en),
    .eth_rx_data      (data),
    .eth_rx_data_valid(valid),
    .eth_rx_frame_good(good),
    .eth_rx_frame_bad (bad),
    .busy             (busy),
    .done             (done),
    .frame_cnt        (frame_cnt),
    .ans_err          (ans_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) chk("strobe_exclusive", {31'd0, (good & bad) | ((good | bad) & valid)}, 32'd0);
    if (valid) vcnt++;
    if (good) gcnt++;
    if (bad) bcnt++;
  end

  function automatic logic [7:0] pat(input int s, input int i);
    return 8'(s * 37 + i * 7 + 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = 13'(addr); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr_len(input int s, input int len, input bit b, input bit na);
    cfg_len_we = 1'b1; cfg_slot = 2'(s); cfg_len = 11'(len);
    cfg_bad = b; cfg_need_answer = na;
    step();
    cfg_len_we = 1'b0;
  endtask

  task automatic load_slot(input int s, input int n);
    for (int i = 0; i < n; i++) wr_byte(s * ML + i, pat(s, i));
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_frame(input int s, input int len, input bit b, input int fc);
    int t = 0;
    while (!valid && t < 200) begin step(); t++; end
    chk("frame_start_seen", {31'd0, valid}, 32'd1);
    for (int i = 0; i < len; i++) begin
      chk("byte_valid", {31'd0, valid}, 32'd1);
      chk("byte_data", {24'd0, data}, {24'd0, pat(s, i)});
      step();
    end
    for (int g = 0; g < GAP; g++) begin
      chk("gap_idle", {29'd0, valid, good, bad}, 32'd0);
      step();
    end
    chk("status_strobe", {30'd0, good, bad}, b ? 32'd1 : 32'd2);
    chk("frame_cnt", frame_cnt, 32'(fc));
    step();
    chk("strobe_one_cycle", {30'd0, good, bad}, 32'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin step(); t++; end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    int sv, sg, sb;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_len_we = 1'b0;
    cfg_slot = '0; cfg_len = '0; cfg_bad = 1'b0; cfg_need_answer = 1'b0;
    start = 1'b0; lp = 1'b0; tx_en = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {26'd0, valid, good, bad, busy, done, ans_err}, 32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_frame_cnt", frame_cnt, 32'd0);
    rst = 1'b0;
    step();

    load_slot(0, 50);
    load_slot(1, 50);
    load_slot(2, 50);

    // Single frame waiting for an answer.
    wr_len(0, 42, 0, 1);
    wr_len(1, 0, 0, 0);
    wr_len(2, 0, 0, 0);
    wr_len(3, 0, 0, 0);
    kick();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("no_valid_in_fetch", {31'd0, valid}, 32'd0);
    step();
    chk("first_byte_latency", {31'd0, valid}, 32'd1);
    check_frame(0, 42, 0, 1);
    wr_byte(5, 8'hEE);
    repeat (8) step();
    chk("hold_for_answer", {29'd0, busy, valid, done}, 32'd4);
    tx_en = 1'b1;
    repeat (3) step();
    tx_en = 1'b0;
    k = 0;
    while (!done && k < 60) begin step(); k++; end
    chk("answer_to_done_cycles", 32'(k), 32'd20);
    chk("t1_frame_cnt", frame_cnt, 32'd1);
    chk("ans_err_clear", {31'd0, ans_err}, 32'd0);
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Good then bad; the busy-time byte write above must not have landed.
    wr_len(0, 42, 0, 0);
    wr_len(1, 50, 1, 0);
    kick();
    check_frame(0, 42, 0, 1);
    check_frame(1, 50, 1, 2);
    wait_done();
    chk("t2_frame_cnt", frame_cnt, 32'd2);

    // Zero-length slot in the middle is skipped.
    wr_len(1, 0, 0, 0);
    wr_len(2, 50, 0, 0);
    sv = vcnt; sg = gcnt; sb = bcnt;
    kick();
    check_frame(0, 42, 0, 1);
    check_frame(2, 50, 0, 2);
    wait_done();
    chk("t3_valid_total", 32'(vcnt - sv), 32'd92);
    chk("t3_strobe_total", 32'((gcnt - sg) + (bcnt - sb)), 32'd2);
    chk("t3_frame_cnt", frame_cnt, 32'd2);

    // Loop over two slots, dropped after the third frame.
    wr_len(1, 50, 1, 0);
    wr_len(2, 0, 0, 0);
    lp = 1'b1;
    kick();
    check_frame(0, 42, 0, 1);
    check_frame(1, 50, 1, 2);
    check_frame(0, 42, 0, 3);
    lp = 1'b0;
    check_frame(1, 50, 1, 4);
    wait_done();
    chk("t4_frame_cnt", frame_cnt, 32'd4);

    // Oversized length clamps to a full last slot.
    load_slot(3, ML);
    wr_len(0, 0, 0, 0);
    wr_len(1, 0, 0, 0);
    wr_len(3, 2000, 0, 0);
    sv = vcnt;
    kick();
    check_frame(3, ML, 0, 1);
    wait_done();
    chk("clamp_valid_total", 32'(vcnt - sv), 32'(ML));

    // Reset in the middle of a frame, then replay.
    wr_len(0, 42, 0, 0);
    wr_len(3, 0, 0, 0);
    kick();
    k = 0;
    while (!valid && k < 50) begin step(); k++; end
    for (int i = 0; i < 20; i++) step();
    chk("byte20_before_reset", {23'd0, valid, data}, {23'd0, 1'b1, pat(0, 20)});
    sg = gcnt; sb = bcnt;
    rst = 1'b1;
    step();
    chk("reset_kills_valid", {30'd0, valid, busy}, 32'd0);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("no_strobe_after_reset", 32'((gcnt - sg) + (bcnt - sb)), 32'd0);
    chk("idle_after_reset", {29'd0, busy, valid, done}, 32'd0);
    chk("cnt_after_reset", frame_cnt, 32'd0);
    kick();
    check_frame(0, 42, 0, 1);
    wait_done();

`ifdef ANSWER_TIMEOUT_EN
    wr_len(0, 42, 0, 1);
    kick();
    check_frame(0, 42, 0, 1);
    k = 1;
    while (!ans_err && k < 300) begin step(); k++; end
    chk("ans_timeout_cycles", 32'(k), 32'd101);
    wait_done();
    chk("ans_err_sticky", {31'd0, ans_err}, 32'd1);
    chk("timeout_frame_cnt", frame_cnt, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_player.md
Name: eth_rx_frame_player

Overview:
Synthesizable, parametrised Ethernet RX frame source. It replays up to NUM_FRAMES stored frames onto a MAC-RX-style byte interface: data/valid, then a one-cycle good/bad status strobe. It sits in front of ip_minimal on hardware loopback rigs and in benches as the frame injector. Per frame, it can hold the next frame until the stack's TX reply has completed.

Parameters:
NUM_FRAMES, 4, number of frame slots.
MAX_LEN, 1536, bytes per slot; frame k occupies addresses k*MAX_LEN .. k*MAX_LEN+MAX_LEN-1.
GAP_CYCLES, 4, idle cycles between the last valid byte and the status strobe.
IFG_CYCLES, 12, idle cycles after a frame completes before the next frame starts.
ANS_TIMEOUT, 65535, answer-wait timeout in cycles (used only with the optional feature).

Ports:
eth_rx_clk  in  1  sole clock.
rst  in  1  synchronous, active-high reset.
cfg_we  in  1  byte write strobe.
cfg_addr  in  clog2(NUM_FRAMES*MAX_LEN)  byte address.
cfg_data  in  8  byte data.
cfg_len_we  in  1  length/flag table write strobe.
cfg_slot  in  clog2(NUM_FRAMES)  slot index for the table write.
cfg_len  in  clog2(MAX_LEN+1)  frame length in bytes.
cfg_bad  in  1  slot ends with frame_bad instead of frame_good.
cfg_need_answer  in  1  wait for the TX reply after this slot.
start  in  1  begin playback at slot 0.
loop  in  1  wrap to slot 0 after the last slot.
eth_tx_data_en  in  1  stack TX activity, used to detect the reply.
eth_rx_data  out  8  frame byte.
eth_rx_data_valid  out  1  byte valid.
eth_rx_frame_good  out  1  one-cycle good-frame strobe.
eth_rx_frame_bad  out  1  one-cycle bad-frame strobe.
busy  out  1  playback in progress.
done  out  1  one-cycle pulse when playback ends.
frame_cnt  out  32  frames played since start; wraps modulo 2^32.
ans_err  out  1  sticky answer-timeout flag.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Frame RAM and the length/flag table are not reset.
- Reset mid-frame: eth_rx_data_valid is 0 on the next cycle. No status strobe is issued.
- Frame RAM: synchronous read, 1-cycle latency. eth_rx_data is registered.
- Config writes while busy=1 are ignored.
- Length writes with cfg_len > MAX_LEN are clamped to MAX_LEN.
- start:
  - Ignored while busy.
  - Sampled high in IDLE at cycle N: busy=1 at N+1; first valid byte at N+2.
- FSM states:
  - IDLE -> FETCH on start.
  - FETCH: read the slot's length and flags. len=0 -> NEXT (slot skipped: no valid, no strobe, frame_cnt unchanged). Otherwise -> PLAY.
  - PLAY: valid high for exactly len consecutive cycles; bytes in address order. Then -> GAP.
  - GAP: GAP_CYCLES idle cycles, then -> STATUS.
  - STATUS: one-cycle good or bad strobe per the slot's flag; frame_cnt+1. Then -> WAIT_RISE if need_answer, else -> IFG.
  - WAIT_RISE: wait for eth_tx_data_en=1 -> WAIT_FALL.
  - WAIT_FALL: wait for eth_tx_data_en=0 -> IFG.
  - IFG: IFG_CYCLES idle cycles, then -> NEXT.
  - NEXT: slot+1. If slot was NUM_FRAMES-1: loop=1 -> slot 0, FETCH; loop=0 -> IDLE with done pulse, busy=0.
- eth_tx_data_en already high on entering WAIT_RISE counts as the rise.
- loop is sampled only in NEXT.
- If all slots have len=0 and loop=1, the FSM spins without output; software must avoid this.
- Good and bad strobes are never high together. Neither strobe is ever high in the same cycle as valid.

Optional Feature:
Macro ANSWER_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RISE/WAIT_FALL. After ANS_TIMEOUT cycles with no transition: set ans_err (sticky until rst) and go to IFG.
- Undefined: waits indefinitely; ans_err is tied to 0.

Decomposition:
- Shared package eth_player_pkg: state enum; slot_cfg struct {len, bad, need_answer}; address/length width functions.
- One sub-module: eth_player_ram, a single-port-write / single-read synchronous byte RAM (infers BRAM).

Test Plan:
- Slot0: 42-byte ARP frame, need_answer=1; start. -> valid for 42 cycles, bytes match; 4 idle cycles; frame_good 1 cycle; hold until tx_data_en rises and falls; 12-cycle IFG; done; frame_cnt=1.
- Slot0 good (42 B), slot1 bad (50 B). -> strobes good then bad; bad never coincident with good; frame_cnt=2.
- Slots 0,2 len 42/50; slot1 len 0. -> exactly two frames emitted; no activity for slot1.
- loop=1 with 2 slots; clear loop during frame 3. -> frames 0,1,0,1 then done; frame_cnt=4.
- rst asserted at byte 20 of 42. -> valid=0 next cycle; no strobe; busy=0. A fresh start replays the retained data correctly.
- ANSWER_TIMEOUT_EN, ANS_TIMEOUT=100, tx_data_en held 0. -> ans_err=1 at 100 cycles after STATUS; playback continues.
